// File: rtl/llki_key_sender.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : llki_key_sender
// Description : Transmitting end of the LLKI discrete key interface. Accepts
//               a load or clear command, fetches 64-bit key words from a key
//               RAM read port, hands them one at a time to a TSS-wrapped core
//               over the llkid_* signals and returns a completion status.
// Revision    : 1.0 - initial release
// ============================================================================
module llki_key_sender #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  input  logic [7:0]        cmd_num_words,
  // key RAM read port
  output logic              keyram_rd,
  output logic [ADDR_W-1:0] keyram_addr,
  input  logic [63:0]       keyram_rdata,
  // LLKI discrete interface to the core
  output logic [63:0]       llkid_key_data,
  output logic              llkid_key_valid,
  input  logic              llkid_key_ready,
  input  logic              llkid_key_complete,
  output logic              llkid_clear_key,
  input  logic              llkid_clear_key_ack,
  // response channel
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] c_OP_LOAD  = 2'b01;
  localparam logic [1:0] c_OP_CLEAR = 2'b10;

  localparam logic [1:0] c_ST_OK    = 2'b00;
  localparam logic [1:0] c_ST_TMO   = 2'b01;
  localparam logic [1:0] c_ST_BAD   = 2'b10;
  localparam logic [1:0] c_ST_EARLY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD        = 3'd1,
    S_CAP       = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_CMPL = 3'd4,
    S_CLR       = 3'd5,
    S_RESP      = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          w_next_status;

  logic [ADDR_W-1:0]   r_base;
  logic [7:0]          r_count;
  logic [7:0]          r_idx;
  logic [c_TMO_W-1:0]  r_tmo;
  logic [63:0]         r_key_data;
  logic                r_key_valid;
  logic                r_clear_key;
  logic                r_rsp_valid;
  logic [1:0]          r_rsp_status;

  logic                w_accept;
  logic                w_last;
  logic                w_tmo_hit;
  logic                w_tmo_state;
  logic [ADDR_W+7:0]   w_addr_sum;

  // r_key_valid is high exactly in SEND, so it doubles as the SEND qualifier
  assign w_accept    = r_key_valid & llkid_key_ready;
  assign w_last      = ({1'b0, r_idx} + 9'd1) == {1'b0, r_count};
  assign w_tmo_hit   = (r_tmo == c_TMO_LAST);
  assign w_tmo_state = (r_state == S_SEND) || (r_state == S_WAIT_CMPL) || (r_state == S_CLR);

  // Address arithmetic is done wide and truncated so the base wraps mod 2^ADDR_W
  assign w_addr_sum  = {8'd0, r_base} + {{ADDR_W{1'b0}}, r_idx};

  assign cmd_ready          = (r_state == S_IDLE);
  assign busy               = (r_state != S_IDLE);
  assign keyram_rd          = (r_state == S_RD);
  assign keyram_addr        = (r_state == S_RD) ? w_addr_sum[ADDR_W-1:0] : '0;
  assign llkid_key_data     = r_key_data;
  assign llkid_key_valid    = r_key_valid;
  assign llkid_clear_key    = r_clear_key;
  assign rsp_valid          = r_rsp_valid;
  assign rsp_status         = r_rsp_status;

  // Next-state and response-status selection
  always_comb begin
    w_next_state  = r_state;
    w_next_status = r_rsp_status;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if ((cmd_op == c_OP_LOAD) && (cmd_num_words != 8'd0)) begin
            w_next_state = S_RD;
          end else if (cmd_op == c_OP_CLEAR) begin
            w_next_state = S_CLR;
          end else begin
            w_next_state  = S_RESP;
            w_next_status = c_ST_BAD;
          end
        end
      end
      S_RD: begin
        if (llkid_key_complete) begin
          w_next_state  = S_RESP;
          w_next_status = c_ST_EARLY;
        end else begin
          w_next_state = S_CAP;
        end
      end
      S_CAP: begin
        if (llkid_key_complete) begin
          w_next_state  = S_RESP;
          w_next_status = c_ST_EARLY;
        end else begin
          w_next_state = S_SEND;
        end
      end
      S_SEND: begin
        // Final-word acceptance wins over a coincident complete
        if (w_accept && w_last) begin
          w_next_state = S_WAIT_CMPL;
        end else if (llkid_key_complete) begin
          w_next_state  = S_RESP;
          w_next_status = c_ST_EARLY;
        end else if (w_accept) begin
          w_next_state = S_RD;
        end else if (w_tmo_hit) begin
          w_next_state  = S_RESP;
          w_next_status = c_ST_TMO;
        end
      end
      S_WAIT_CMPL: begin
        if (llkid_key_complete) begin
          w_next_state  = S_RESP;
          w_next_status = c_ST_OK;
        end else if (w_tmo_hit) begin
          w_next_state  = S_RESP;
          w_next_status = c_ST_TMO;
        end
      end
      S_CLR: begin
        if (llkid_clear_key_ack) begin
          w_next_state  = S_RESP;
          w_next_status = c_ST_OK;
        end else if (w_tmo_hit) begin
          w_next_state  = S_RESP;
          w_next_status = c_ST_TMO;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_key_valid  <= 1'b0;
      r_clear_key  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= c_ST_OK;
    end else begin
      r_state      <= w_next_state;
      r_key_valid  <= (w_next_state == S_SEND);
      r_clear_key  <= (w_next_state == S_CLR);
      r_rsp_valid  <= (w_next_state == S_RESP);
      r_rsp_status <= w_next_status;
    end
  end

  // Command latch and word index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base  <= '0;
      r_count <= 8'd0;
      r_idx   <= 8'd0;
    end else if ((r_state == S_IDLE) && cmd_valid) begin
      r_base  <= cmd_base_addr;
      r_count <= cmd_num_words;
      r_idx   <= 8'd0;
    end else if ((r_state == S_SEND) && w_accept) begin
      r_idx   <= r_idx + 8'd1;
    end
  end

  // Wait-state timeout counter; restarts on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
    end else if (w_next_state != r_state) begin
      r_tmo <= '0;
    end else if (w_tmo_state) begin
      r_tmo <= r_tmo + c_TMO_W'(1);
    end
  end

  // Capture the RAM word returned for the read issued in RD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_data <= 64'd0;
    end else if (r_state == S_CAP) begin
      r_key_data <= keyram_rdata;
    end
  end

endmodule
`default_nettype wire
